// File: rtl/phv_assembler_pkg.sv
// Shared widths and group indices for the PHV assembler slice.
// Container widths, tail width and full-PHV length are common with the crossbar.
package phv_assembler_pkg;

    localparam int WIDTH_2B         = 16;
    localparam int WIDTH_4B         = 32;
    localparam int WIDTH_6B         = 48;
    localparam int TAIL_W           = 256;
    localparam int DEF_NUM_PER_TYPE = 8;
    localparam int DEF_GRP_DEPTH    = 4;
    localparam int NUM_GRP          = 4;

    typedef enum logic [1:0] {
        GRP_6B  = 2'd0,
        GRP_4B  = 2'd1,
        GRP_2B  = 2'd2,
        GRP_REM = 2'd3
    } grp_e;

    function automatic int phv_len(input int num_per_type);
        return (WIDTH_6B + WIDTH_4B + WIDTH_2B) * num_per_type + TAIL_W;
    endfunction

endpackage

// File: rtl/phv_assembler_if.sv
// ALU-result / metadata input bundle and rebuilt-PHV output bundle of the assembler.
// master = upstream/downstream environment, slave = the assembler itself.
interface phv_assembler_if
    import phv_assembler_pkg::*;
#(
    parameter int NUM_PER_TYPE = DEF_NUM_PER_TYPE
);
    localparam int PHV_LEN = phv_len(NUM_PER_TYPE);

    logic [WIDTH_6B*NUM_PER_TYPE-1:0] alu_6B_out;
    logic                             alu_6B_valid;
    logic [WIDTH_4B*NUM_PER_TYPE-1:0] alu_4B_out;
    logic                             alu_4B_valid;
    logic [WIDTH_2B*NUM_PER_TYPE-1:0] alu_2B_out;
    logic                             alu_2B_valid;
    logic [TAIL_W-1:0]                phv_remain_data;
    logic                             phv_remain_valid;
    logic                             ready_out;
    logic [PHV_LEN-1:0]               phv_out;
    logic                             phv_out_valid;
    logic                             ready_in;
    logic [31:0]                      phv_cnt;
    logic                             overflow_err;

    modport master (
        output alu_6B_out, alu_6B_valid, alu_4B_out, alu_4B_valid,
        output alu_2B_out, alu_2B_valid, phv_remain_data, phv_remain_valid,
        output ready_in,
        input  ready_out, phv_out, phv_out_valid, phv_cnt, overflow_err
    );

    modport slave (
        input  alu_6B_out, alu_6B_valid, alu_4B_out, alu_4B_valid,
        input  alu_2B_out, alu_2B_valid, phv_remain_data, phv_remain_valid,
        input  ready_in,
        output ready_out, phv_out, phv_out_valid, phv_cnt, overflow_err
    );

endinterface

// File: rtl/phv_grp_fifo.sv
// Per-group result queue with first-word head always visible on rd_data.
// Latency: write visible at head one cycle later; a full FIFO accepts a write only alongside a pop.
// Backpressure: none internally; writes to a full FIFO without a pop are dropped.
module phv_grp_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/phv_assembler.sv
// Merges the 6B/4B/2B ALU result groups and the metadata tail back into one PHV per packet.
// Latency: PHV valid one cycle after its last group is written, when the output register is free.
// Backpressure: ready_in stalls the output register; registered ready_out drops with one entry of slack.
module phv_assembler
    import phv_assembler_pkg::*;
#(
    parameter int STAGE_ID     = 0,
    parameter int NUM_PER_TYPE = DEF_NUM_PER_TYPE,
    parameter int GRP_DEPTH    = DEF_GRP_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    phv_assembler_if.slave  bus
);
    localparam int W6      = WIDTH_6B * NUM_PER_TYPE;
    localparam int W4      = WIDTH_4B * NUM_PER_TYPE;
    localparam int W2      = WIDTH_2B * NUM_PER_TYPE;
    localparam int PHV_LEN = phv_len(NUM_PER_TYPE);
    localparam int CW      = $clog2(GRP_DEPTH) + 1;

    if (GRP_DEPTH < 2 || (GRP_DEPTH & (GRP_DEPTH - 1)) != 0 || STAGE_ID < 0) begin : g_bad_param
        $error("phv_assembler: GRP_DEPTH must be a power of 2 >= 2 and STAGE_ID non-negative");
    end

    logic [W6-1:0]      head_6b;
    logic [W4-1:0]      head_4b;
    logic [W2-1:0]      head_2b;
    logic [TAIL_W-1:0]  head_rem;
    logic [NUM_GRP-1:0] wr;
    logic [NUM_GRP-1:0] empty;
    logic [NUM_GRP-1:0] full;
    logic [CW-1:0]      cnt [NUM_GRP];
    logic               merge;
    logic               rdy_nxt;
    logic [CW-1:0]      occ_nxt;

    logic [PHV_LEN-1:0] phv_q;
    logic               vld_q;
    logic [31:0]        cnt_q;
    logic               rdy_q;
    logic               ovf_q;

    assign wr[GRP_6B]  = bus.alu_6B_valid;
    assign wr[GRP_4B]  = bus.alu_4B_valid;
    assign wr[GRP_2B]  = bus.alu_2B_valid;
    assign wr[GRP_REM] = bus.phv_remain_valid;

    assign merge = !(|empty) && (!vld_q || bus.ready_in);

    phv_grp_fifo #(.WIDTH(W6), .DEPTH(GRP_DEPTH)) u_fifo_6b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr[GRP_6B]), .wr_data(bus.alu_6B_out), .rd_en(merge), .rd_data(head_6b),
        .empty(empty[GRP_6B]), .full(full[GRP_6B]), .count(cnt[GRP_6B])
    );

    phv_grp_fifo #(.WIDTH(W4), .DEPTH(GRP_DEPTH)) u_fifo_4b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr[GRP_4B]), .wr_data(bus.alu_4B_out), .rd_en(merge), .rd_data(head_4b),
        .empty(empty[GRP_4B]), .full(full[GRP_4B]), .count(cnt[GRP_4B])
    );

    phv_grp_fifo #(.WIDTH(W2), .DEPTH(GRP_DEPTH)) u_fifo_2b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr[GRP_2B]), .wr_data(bus.alu_2B_out), .rd_en(merge), .rd_data(head_2b),
        .empty(empty[GRP_2B]), .full(full[GRP_2B]), .count(cnt[GRP_2B])
    );

    phv_grp_fifo #(.WIDTH(TAIL_W), .DEPTH(GRP_DEPTH)) u_fifo_rem (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr[GRP_REM]), .wr_data(bus.phv_remain_data), .rd_en(merge), .rd_data(head_rem),
        .empty(empty[GRP_REM]), .full(full[GRP_REM]), .count(cnt[GRP_REM])
    );

    // Post-edge occupancy of every group; ready_out reflects the state after this edge.
    always_comb begin
        rdy_nxt = 1'b1;
        occ_nxt = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            occ_nxt = cnt[g];
            if (wr[g] && (!full[g] || merge)) occ_nxt = occ_nxt + 1'b1;
            if (merge)                        occ_nxt = occ_nxt - 1'b1;
            if (occ_nxt > CW'(GRP_DEPTH - 2)) rdy_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_q <= '0;
            vld_q <= 1'b0;
            cnt_q <= '0;
            rdy_q <= 1'b1;
            ovf_q <= 1'b0;
        end else begin
            if (merge) begin
                phv_q <= {head_6b, head_4b, head_2b, head_rem};
                vld_q <= 1'b1;
                cnt_q <= cnt_q + 32'd1;
            end else if (bus.ready_in) begin
                vld_q <= 1'b0;
            end
            rdy_q <= rdy_nxt;
            if (|(wr & full & ~{NUM_GRP{merge}})) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.phv_out       = phv_q;
    assign bus.phv_out_valid = vld_q;
    assign bus.phv_cnt       = cnt_q;
    assign bus.ready_out     = rdy_q;
    assign bus.overflow_err  = ovf_q;

endmodule

// File: doc/phv_assembler.md
Name: phv_assembler

Overview:
- Stage back-end that collects per-type ALU results and remaining metadata, then rebuilds one full PHV per packet for the next RMT stage.
- Sits downstream of the ALU array, opposite the operand crossbar.
- ALU groups may finish with different latencies; for example, stateful 4B ALUs are slower. Each result group is queued independently, and the groups are merged in packet order.

Parameters:
- STAGE_ID, 0, stage index; informational only.
- NUM_PER_TYPE, 8, containers per type.
- width_2B, 16, 2B container width.
- width_4B, 32, 4B container width.
- width_6B, 48, 6B container width.
- PHV_LEN, 48*NUM_PER_TYPE+32*NUM_PER_TYPE+16*NUM_PER_TYPE+256, full PHV width.
- GRP_DEPTH, 4, entries per group FIFO; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_6B_out  in  width_6B*NUM_PER_TYPE  6B ALU results; container i is at [(i+1)*48-1 -: 48].
- alu_6B_valid  in  1  6B group valid.
- alu_4B_out  in  width_4B*NUM_PER_TYPE  4B ALU results.
- alu_4B_valid  in  1  4B group valid.
- alu_2B_out  in  width_2B*NUM_PER_TYPE  2B ALU results.
- alu_2B_valid  in  1  2B group valid.
- phv_remain_data  in  256  metadata tail.
- phv_remain_valid  in  1  tail valid.
- ready_out  out  1  back-pressure to the crossbar and ALUs; registered.
- phv_out  out  PHV_LEN  reassembled PHV.
- phv_out_valid  out  1  output valid.
- ready_in  in  1  downstream ready.
- phv_cnt  out  32  number of PHVs emitted.
- overflow_err  out  1  sticky flag: a group write arrived while its FIFO was full.

Behaviour:
- Reset values: phv_out=0, phv_out_valid=0, ready_out=1, phv_cnt=0, overflow_err=0. All four FIFOs are empty. Reset mid-operation discards all queued data immediately.
- Group FIFOs: one each for 6B, 4B, 2B and remain.
  - Each FIFO writes on its own valid signal.
  - Each group arrives exactly once per packet, in packet order. Groups are never reordered across packets.
- Overflow: a write to a full FIFO with no simultaneous pop is dropped and sets overflow_err until reset. The other FIFOs are unaffected.
- A write and a pop in the same cycle on a full FIFO is legal; occupancy stays unchanged.
- Merge condition: all four FIFOs are non-empty AND (!phv_out_valid || ready_in).
- Merge action:
  - Pop the head of all four FIFOs in the same cycle.
  - Load phv_out = {head6B, head4B, head2B, headRemain}, so 6B container 7 sits at the MSB and the tail at [255:0].
  - Set phv_out_valid=1 and increment phv_cnt; phv_cnt wraps at 2^32.
- If the merge condition is false and ready_in=1, phv_out_valid goes to 0 and phv_out holds its last value.
- While phv_out_valid=1 and ready_in=0, phv_out is stable.
- Latency: all groups written at edge N into empty FIFOs gives phv_out_valid=1 after edge N+1. Otherwise the PHV is emitted one cycle after its last group arrives, provided output is free.
- Throughput: one PHV per cycle sustained when ready_in=1.
- ready_out is registered. It is 1 when, after the current edge, every FIFO holds at most GRP_DEPTH-2 entries. The one-entry slack absorbs one in-flight beat after deassertion.
- Simultaneous events: a write and a merge pop in the same cycle are both honoured. A group arriving for packet k+1 while packet k is incomplete is queued behind packet k.

Decomposition:
- Shared header rmt_defs.vh holds width_2B/4B/6B, NUM_PER_TYPE default, PHV_LEN expression and the 256-bit tail width; the crossbar uses the same header.
- Sub-module phv_grp_fifo (params WIDTH, DEPTH):
  - Ports: wr_en, wr_data, rd_en, rd_data, empty, full, count.
  - Async active-low reset, first-word head always visible on rd_data.
  - Instantiated four times.
- Top level holds the merge/output register, phv_cnt, ready_out and overflow_err logic.

Test Plan:
- Aligned groups: all four valids at edge 0 with 6B=all 0x111111111111, 4B=all 0xAAAAAAAA, 2B=all 0x5555, tail=0 -> phv_out_valid after edge 1; phv_out[PHV_LEN-1 -: 48]=0x111111111111, phv_out[255:0]=0; phv_cnt=1.
- Skewed latency: 6B/2B/tail for packets A and B at edges 0 and 1; 4B for A at edge 3 and for B at edge 4 -> PHV A after edge 4 and B after edge 5, each with correct groups; no overflow_err.
- Back-pressure: ready_in=0 for 6 cycles while aligned packets stream in -> phv_out stable; ready_out falls when occupancy reaches GRP_DEPTH-1 (3 entries); after ready_in=1, all packets emerge in order; phv_cnt is exact.
- Overflow: ignore ready_out and push 5 2B groups with no other groups -> the fifth is dropped, overflow_err=1 and stays 1; other FIFOs' counts unchanged.
- Full plus pop: 2B FIFO full, merge pops it in the same cycle as a new 2B write -> occupancy remains 4; no overflow_err.
- Reset mid-stream: assert rst_n=0 with 3 entries queued and phv_out_valid=1 -> all outputs return to reset values immediately; the first post-reset PHV contains only post-reset data.
